// File: rtl/rr_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_sel_pkg
// Description : Shared sizes and FSM state encoding for the four-requester
//               round-robin select encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_sel_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GRANT = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational rotating-priority picker. The search starts
//               one past the last served index and wraps modulo four.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import rr_sel_pkg::*;
(
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   win,
    output logic               hit
);

    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    // Walk last+1, last+2, last+3, last+4 (== last) and keep the first set bit.
    always_comb begin
        win     = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = last + SEL_W'(k + 1);
            if (!w_found && REQ[w_idx]) begin
                win     = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign hit = |REQ;

endmodule
`default_nettype wire

// File: rtl/rr_sel_encoder4.sv
`default_nettype none
// ============================================================================
// Module      : rr_sel_encoder4
// Description : Round-robin grant sequencer driving the select inputs of a
//               2-to-4 decoder. Selects are loaded only on IDLE->ARM and are
//               held stable for the whole grant; GNT_VLD qualifies the
//               decoder outputs and a hold limit forces release.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_sel_encoder4
    import rr_sel_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic               CLK,
    input  logic               RSTB,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic               DONE,
    output logic               SEL1,
    output logic               SEL0,
    output logic               GNT_VLD,
    output logic               TIMEOUT
);

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel,   w_sel_nxt;
    logic [SEL_W-1:0] r_last,  w_last_nxt;
    logic             r_gnt,   w_gnt_nxt;
    logic             r_to,    w_to_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

    logic [SEL_W-1:0] w_win;
    logic             w_hit;
    logic             w_sel_req;
    logic             w_hold_hit;

    rr_pick4 u_pick (
        .REQ  (REQ),
        .last (r_last),
        .win  (w_win),
        .hit  (w_hit)
    );

    assign w_sel_req  = REQ[r_sel];
    assign w_hold_hit = (r_cnt == c_HOLD_LAST);

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = 1'b0;
        w_to_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_sel_nxt   = w_win;
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                if (w_sel_req) begin
                    w_gnt_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = GRANT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT: begin
                w_gnt_nxt = 1'b1;
                // Saturate at the limit; release is forced there anyway.
                if (!w_hold_hit) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                if (DONE || !w_sel_req || w_hold_hit) begin
                    w_gnt_nxt   = 1'b0;
                    w_last_nxt  = r_sel;
                    w_state_nxt = GAP;
                    // Only a release caused by the hold limit alone is a timeout.
                    w_to_nxt    = w_hold_hit && !DONE && w_sel_req;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset gives index 0 first priority.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_last  <= 2'b11;
            r_gnt   <= 1'b0;
            r_to    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            r_to    <= w_to_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign SEL1    = r_sel[1];
    assign SEL0    = r_sel[0];
    assign GNT_VLD = r_gnt;
    assign TIMEOUT = r_to;

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_encoder4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_sel_encoder4
// Description : Directed self-checking bench for rr_sel_encoder4. Expected
//               per-cycle outputs are queued as each stimulus step is driven
//               and compared after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_sel_encoder4;

    typedef struct packed {
        logic [1:0] sel;
        logic       gnt;
        logic       to;
    } exp_t;

    logic       CLK;
    logic       RSTB;
    logic [3:0] REQ;
    logic       DONE;
    logic       SEL1, SEL0, GNT_VLD, TIMEOUT;

    exp_t  sb[$];
    int    n_checks;
    int    n_pass;
    string tname;

    rr_sel_encoder4 #(.MAX_HOLD(8)) dut (
        .CLK     (CLK),
        .RSTB    (RSTB),
        .REQ     (REQ),
        .DONE    (DONE),
        .SEL1    (SEL1),
        .SEL0    (SEL0),
        .GNT_VLD (GNT_VLD),
        .TIMEOUT (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s/%s observed=%0h expected=%0h", tname, tag, obs, expv);
    endtask

    task automatic check_outs(input logic [1:0] esel, input logic egnt, input logic eto);
        check("sel",     {2'b00, SEL1, SEL0}, {2'b00, esel});
        check("gnt_vld", {3'b000, GNT_VLD},   {3'b000, egnt});
        check("timeout", {3'b000, TIMEOUT},   {3'b000, eto});
    endtask

    // Drive one cycle of inputs, queue what the outputs must be after the edge.
    task automatic step(input logic [3:0] req, input logic done,
                        input logic [1:0] esel, input logic egnt, input logic eto);
        exp_t e;
        REQ  = req;
        DONE = done;
        e.sel = esel;
        e.gnt = egnt;
        e.to  = eto;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check_outs(e.sel, e.gnt, e.to);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RSTB = 1'b0;
        REQ  = 4'b0000;
        DONE = 1'b0;
        #1;
        check_outs(2'b00, 1'b0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RSTB = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RSTB = 1'b0;
        REQ  = 4'b0000;
        DONE = 1'b0;

        tname = "reset";
        repeat (2) @(posedge CLK);
        #1;
        check_outs(2'b00, 1'b0, 1'b0);
        @(negedge CLK);
        RSTB = 1'b1;

        // Single requester, DONE in the third grant cycle.
        tname = "single";
        step(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // All requesting: rotation 0,1,2,3,0 with two-cycle grants.
        tname = "rotate";
        do_reset();
        for (int g = 0; g < 5; g++) begin
            logic [1:0] s;
            s = 2'(g);
            step(4'b1111, 1'b0, s, 1'b0, 1'b0);
            step(4'b1111, 1'b0, s, 1'b1, 1'b0);
            step(4'b1111, 1'b0, s, 1'b1, 1'b0);
            step(4'b1111, 1'b1, s, 1'b0, 1'b0);
            step(4'b1111, 1'b0, s, 1'b0, 1'b0);
        end

        // Hold limit: eight grant cycles, timeout pulse, regrant to index 2.
        tname = "timeout";
        do_reset();
        step(4'b0100, 1'b0, 2'd2, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) step(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 2'd2, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 2'd2, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 2'd2, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);

        // Request withdrawn during ARM: no grant, priority unchanged.
        tname = "arm_drop";
        do_reset();
        step(4'b0010, 1'b0, 2'd1, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
        step(4'b0011, 1'b1, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // DONE coinciding with the hold limit is a normal release.
        tname = "done_at_limit";
        do_reset();
        step(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) step(4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-grant, then priority restarts at index 0.
        tname = "async_rst";
        do_reset();
        step(4'b0100, 1'b0, 2'd2, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        #2;
        RSTB = 1'b0;
        #1;
        check_outs(2'b00, 1'b0, 1'b0);
        REQ = 4'b1100;
        @(negedge CLK);
        @(negedge CLK);
        RSTB = 1'b1;
        step(4'b1100, 1'b0, 2'd2, 1'b0, 1'b0);
        step(4'b1100, 1'b0, 2'd2, 1'b1, 1'b0);
        step(4'b1100, 1'b1, 2'd2, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
